lsu_arbiter: RTL

Shares the single-ported load/store unit between NUM_REQ requesters, for example the core data port and the debug/loader port.
- Round-robin arbitration over a valid/ready request handshake.
- Sequences each accepted transaction into the LSU: one-cycle write strobe, fixed read-latency wait, then a one-cycle response pulse to the granted requester.
- Rejects misaligned or illegal-dtype accesses without touching memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_rr_picker.sv | 38 +++
 rtl/lsu_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU arbiter.
//   dtype_e       : LSU data-type encodings as seen on dtypes_in
//   state_e       : sequencing states of the arbiter
//   dtype_aligned : address/dtype legality check (illegal dtypes report 0)
package lsu_pkg;

    localparam int unsigned DtypeWidth = 3;

    typedef enum logic [DtypeWidth-1:0] {
        DtByte             = 3'b000,
        DtHalfWord         = 3'b001,
        DtFullWord         = 3'b010,
        DtByteUnsigned     = 3'b011,
        DtHalfWordUnsigned = 3'b100
    } dtype_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    // Only the two low address bits matter for natural alignment.
    function automatic logic dtype_aligned(input logic [1:0]            addr_lo,
                                           input logic [DtypeWidth-1:0] dtype);
        logic ok;
        ok = 1'b0;
        case (dtype)
            DtByte, DtByteUnsigned:         ok = 1'b1;
            DtHalfWord, DtHalfWordUnsigned: ok = ~addr_lo[0];
            DtFullWord:                     ok = (addr_lo == 2'b00);
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_rr_picker.sv
// Combinational round-robin picker.
//   valid_i  : per-requester valid vector
//   rr_ptr_i : requester with highest priority this cycle
//   grant_o  : one-hot grant (all zero when nothing is valid)
//   winner_o : index of the granted requester (0 when nothing is valid)
module lsu_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      winner_o
);

    int unsigned idx;
    logic        found;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid wins.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid_i[IW'(idx)]) begin
                found              = 1'b1;
                grant_o[IW'(idx)]  = 1'b1;
                winner_o           = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one single-ported LSU between NUM_REQ requesters.
// Each accepted request is sequenced as: address cycle (ACCESS, one-cycle write
// strobe for stores), fixed read-latency wait for loads, then a one-cycle
// response pulse to the owner. Misaligned or illegal-dtype requests go straight
// to an error response and never reach the LSU.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid_i/ready_o : per-requester request handshake (ready is one-hot)
//   req_addr_i/wdata_i/we_i/dtype_i : packed per-requester request fields
//   rsp_valid_o         : one-cycle response pulse to the owning requester
//   rsp_rdata_o/err_o   : shared response data / error flag
//   lsu_*_o, lsu_data_i : LSU interface
//   busy_o              : high whenever a transaction is in flight
//   stat_grants_o       : per-requester saturating grant counters, present only
//                         when LSU_ARBITER_STATS_EN is defined
module lsu_arbiter
    import lsu_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDRESS_SPACE  = 4096,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_DATA_TYPES = 6,
    parameter int unsigned LSU_LATENCY    = 1,
    localparam int unsigned AW  = $clog2(ADDRESS_SPACE),
    localparam int unsigned DTW = $clog2(NUM_DATA_TYPES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*AW-1:0]           req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ-1:0]              req_we_i,
    input  logic [NUM_REQ*DTW-1:0]          req_dtype_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic [AW-1:0]                   lsu_addr_o,
    output logic [DATA_WIDTH-1:0]           lsu_data_o,
    output logic                            lsu_we_o,
    output logic [DTW-1:0]                  lsu_dtype_o,
    input  logic [DATA_WIDTH-1:0]           lsu_data_i,
    output logic                            busy_o
`ifdef LSU_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           stat_grants_o
`endif
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = 3;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         owner_q;
    logic                  we_q;
    logic                  err_q;
    logic [AW-1:0]         lsu_addr_q;
    logic [DATA_WIDTH-1:0] lsu_wdata_q;
    logic [DTW-1:0]        lsu_dtype_q;

    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         winner;
    logic                  accept;
    logic                  legal;
    logic [IW-1:0]         rr_next;

    // Unpacked views of the packed request buses.
    logic [AW-1:0]         addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [DTW-1:0]        dtype_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*AW +: AW];
        assign wdata_arr[g] = req_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign dtype_arr[g] = req_dtype_i[g*DTW +: DTW];
    end

    lsu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    always_comb begin
        accept  = (state_q == StIdle) && (|grant);
        legal   = dtype_aligned(addr_arr[winner][1:0], dtype_arr[winner]);
        rr_next = (winner == IW'(NUM_REQ - 1)) ? '0 : IW'(winner + 1'b1);
    end

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rdata_d = '0;
                    state_d = legal ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (we_q) begin
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                    cnt_d   = CW'(LSU_LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rdata_d = lsu_data_i;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        // Ready is gated by reset too, since the state already reads IDLE then.
        req_ready_o = ((state_q == StIdle) && !reset) ? grant : '0;
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = (state_q == StResp) && (owner_q == IW'(i));
        end
        rsp_err_o   = (state_q == StResp) && err_q;
        rsp_rdata_o = (state_q == StResp) ? rdata_q : '0;
        lsu_we_o    = (state_q == StAccess) && we_q;
        lsu_addr_o  = lsu_addr_q;
        lsu_data_o  = lsu_wdata_q;
        lsu_dtype_o = lsu_dtype_q;
        busy_o      = (state_q != StIdle);
    end

    // ---------------------------------------------------------------- request capture
    // LSU-facing registers only load for legal requests so a rejected access
    // never shows up on the LSU port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
            lsu_dtype_q <= DTW'(DtFullWord);
        end else if (accept) begin
            rr_ptr_q <= rr_next;
            owner_q  <= winner;
            we_q     <= req_we_i[winner];
            err_q    <= ~legal;
            if (legal) begin
                lsu_addr_q  <= addr_arr[winner];
                lsu_wdata_q <= wdata_arr[winner];
                lsu_dtype_q <= dtype_arr[winner];
            end
        end
    end

`ifdef LSU_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else if (accept) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if ((winner == IW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign stat_grants_o[g*16 +: 16] = grant_cnt_q[g];
    end
`endif

endmodule
